// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and pointer conversions.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package fifo_pkg;

    localparam int DEF_DSIZE       = 8;
    localparam int DEF_ASIZE       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Binary/Gray pointer for the default geometry (ASIZE+1 bits: address plus wrap bit).
    typedef logic [DEF_ASIZE:0] ptr_t;

    // Both conversions work on zero-extended 32-bit values, so they are correct for
    // any pointer width up to 32: callers extend in and size-cast the result back.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_sync_nff.sv
// N-flop synchroniser chain for Gray-coded pointers crossing clock domains.
// Latency: STAGES clk_i edges from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk_i destination clock, arst_n_i async active-low reset, d_i source-domain
//        value, q_o synchronised value.
`timescale 1ns/1ps
module cdc_sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock Gray-pointer FIFO with fill levels, programmable almost flags and
// optional sticky overflow/underflow flags (enabled by ASYNC_FIFO_ERR_FLAGS_EN).
// Latency: write visible to reader after SYNC_STAGES+1 rclk edges; rdata is show-ahead.
// Backpressure: writes dropped while wfull, reads ignored while rempty.
// Ports: write side wclk/wrst_n/wdata/winc/af_thresh -> wfull/walmost_full/wlevel;
//        read side rclk/rrst_n/rinc/ae_thresh -> rdata/rempty/ralmost_empty/rlevel;
//        woverflow/runderflow only when the macro is defined.
`timescale 1ns/1ps
module async_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DSIZE       = DEF_DSIZE,
    parameter int ASIZE       = DEF_ASIZE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic [ASIZE:0]   af_thresh,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    input  logic             rinc,
    input  logic [ASIZE:0]   ae_thresh,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             woverflow,
    output logic             runderflow
`endif
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ASIZE + 1;

    logic [DSIZE-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wq_rptr, wq_rbin;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          wr_acc;

    cdc_sync_nff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk_i    (wclk),
        .arst_n_i (wrst_n),
        .d_i      (rptr_q),
        .q_o      (wq_rptr)
    );

    always_comb begin
        wr_acc   = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(wr_acc);
        wptr_d   = PW'(bin2gray(32'(wbin_d)));
        wq_rbin  = PW'(gray2bin(32'(wq_rptr)));
        // Stale read pointer can only make this larger than the true fill.
        wlevel_d = wbin_d - wq_rbin;
        // Full: same address, opposite wrap; in Gray that flips the top two bits.
        wfull_d  = (wptr_d == {~wq_rptr[ASIZE:ASIZE-1], wq_rptr[ASIZE-2:0]});
        walmost_full_d = (wlevel_d >= af_thresh);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    // Storage has no reset; contents are only observable behind valid pointers.
    always_ff @(posedge wclk) begin
        if (wr_acc) begin
            mem[wbin_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;

    // ---------------- read domain ----------------
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rq_wptr, rq_wbin;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          rd_acc;

    cdc_sync_nff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk_i    (rclk),
        .arst_n_i (rrst_n),
        .d_i      (wptr_q),
        .q_o      (rq_wptr)
    );

    always_comb begin
        rd_acc   = rinc & ~rempty_q;
        rbin_d   = rbin_q + PW'(rd_acc);
        rptr_d   = PW'(bin2gray(32'(rbin_d)));
        rq_wbin  = PW'(gray2bin(32'(rq_wptr)));
        // Stale write pointer can only make this smaller than the true fill.
        rlevel_d = rq_wbin - rbin_d;
        rempty_d = (rptr_d == rq_wptr);
        ralmost_empty_d = (rlevel_d <= ae_thresh);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign rdata         = mem[rbin_q[ASIZE-1:0]];
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    // ---------------- sticky access errors ----------------
    logic woverflow_q;
    logic runderflow_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow_q <= 1'b0;
        end else if (winc && wfull_q) begin
            woverflow_q <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow_q <= 1'b0;
        end else if (rinc && rempty_q) begin
            runderflow_q <= 1'b1;
        end
    end

    assign woverflow  = woverflow_q;
    assign runderflow = runderflow_q;
`endif

endmodule
